seq_divider_6bit: RTL
=====================

// Module: seq_divider_6bit
// PURPOSE
//  Sequential restoring divider: the inverse of the 6x6 array multiplier.
//  Divides a 12-bit dividend (product width) by a 6-bit divisor, one quotient bit per clock.
//  Gives 6-bit quotient and remainder, with divide-by-zero and overflow flags.
//  Start/busy/done handshake.
//  For p = a*b from the multiplier, p / b returns quotient = a and remainder = 0.
// PARAMETERS
//  N  6  operand width; dividend is 2N bits; quotient and remainder are N bits
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   synchronous reset, active low
//  start        in   1   request a divide; sampled only in IDLE
//  dividend     in   12  dividend, sampled when start is accepted
//  divisor      in   6   divisor, sampled when start is accepted
//  busy         out  1   high while in RUN or DONE
//  done         out  1   one-cycle pulse; results valid from this cycle on
//  quotient     out  6   quotient; held until the next accepted start
//  remainder    out  6   remainder; held until the next accepted start
//  div_by_zero  out  1   error flag: divisor == 0; valid with done
//  overflow     out  1   error flag: quotient does not fit in N bits; valid with done
// BEHAVIOUR
//  Reset/clock
//   - One clock domain (clk). rst_n is synchronous, active low.
//   - rst_n = 0 at an edge gives: state = IDLE; busy, done, quotient, remainder,
//     div_by_zero and overflow all 0; counter = 0.
//   - Reset wins over every other event, including mid-RUN; the operation in flight is discarded.
//  FSM states: IDLE, RUN, DONE
//   - IDLE, start = 1: latch operands and clear both flags.
//       divisor == 0                -> DONE, div_by_zero = 1, quotient = 0, remainder = 0
//       else dividend[11:6] >= divisor -> DONE, overflow = 1, quotient = 0, remainder = 0
//       else                        -> RUN, R = {1'b0, dividend[11:6]}, count = N-1
//   - RUN, every edge:
//       T = {R[5:0], dividend_reg[count]}   (7 bits)
//       if T >= {1'b0, divisor}: R = T - divisor, q[count] = 1
//       else:                    R = T,           q[count] = 0
//       count == 0 -> DONE, with quotient = q and remainder = R[5:0]
//   - DONE: done = 1 for exactly one cycle, then IDLE unconditionally.
//  Latency
//   - Normal divide: done is high in the cycle after the (N+1)th edge counted from the
//     start-accept edge (accept edge, then N RUN edges). Default N = 6 gives 7 edges.
//   - Error case: done is high in the cycle after the accept edge.
//  Handshake
//   - start is ignored in RUN and DONE; there is no queueing.
//   - Back-to-back: start held high is accepted again in the first IDLE cycle after done.
//   - dividend and divisor may change freely after the accept edge.
//  Arithmetic
//   - All arithmetic is unsigned.
//   - R is N+1 bits; the trial subtract is N+1 bits wide; its borrow-out selects restore.
//   - The overflow pre-check guarantees R[N] = 0 after every RUN step and remainder < divisor.
//   - Flags: div_by_zero takes priority over overflow; at most one flag is set per operation.
//   - Flags hold until the next accepted start or reset.
// STRUCTURE
//  Shared package div_pkg:
//   - N default
//   - state encoding localparams: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2 (2'd3 decodes as IDLE)
//   - counter width $clog2(N)
//  One sub-module: rca_sub_7bit
//   - N+1-bit ripple subtractor built from the existing full_adder cell
//   - b is inverted and cin = 1
//   - outputs diff[N:0] and borrow_n (cout)
//  Top level holds the FSM, counter, dividend_reg, divisor_reg, R, q and the restore mux.
// TESTING
//  1. reset, start with 3969 / 63 -> done after 7 edges; q = 63, r = 0, both flags 0,
//     busy high from the accept edge up to done.
//  2. 1166 / 22 (53*22) -> q = 53, r = 0.
//     Then 1170 / 22 -> q = 53, r = 4.
//  3. 100 / 0 -> done in the cycle after the accept edge; div_by_zero = 1, overflow = 0,
//     q = 0, r = 0.
//     Then 4032 / 63 -> overflow = 1, div_by_zero = 0, q = 0, r = 0.
//  4. 4031 / 63 -> q = 63, r = 62 (boundary just below overflow).
//     Then 0 / 1 -> q = 0, r = 0.
//  5. start pulsed again mid-RUN with other operands -> ignored; original result returned.
//     start held high -> second accept in the first IDLE cycle after done.
//  6. rst_n low at RUN cycle 3 -> next cycle all outputs 0 and state IDLE.
//     A new 63 / 7 then completes normally with q = 9, r = 0.
//  Scoreboard: random sweep of all divisors 1..63 against a behavioural / and %.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   N_DEF     : default operand width (dividend is 2*N_DEF bits)
//   CNT_W_DEF : bit-counter width for the default operand width
//   IDLE/RUN/DONE : FSM state encodings (2'd3 is treated as IDLE)
package div_pkg;

   localparam int N_DEF     = 6;
   localparam int CNT_W_DEF = $clog2(N_DEF);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_sub_7bit.sv
// Ripple-carry subtractor diff = a - b, built from full_adder cells
// as a + ~b + 1.
//   a, b     : W-bit unsigned operands
//   diff     : W-bit difference (modulo 2^W)
//   borrow_n : carry out of the top cell; 1 means a >= b (no borrow)
module rca_sub_7bit #(
   parameter int W = 7
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow_n
);

   logic [W:0] carry;

   assign carry[0] = 1'b1;

   for (genvar i = 0; i < W; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (~b[i]),
         .cin  (carry[i]),
         .sum  (diff[i]),
         .cout (carry[i+1])
      );
   end

   assign borrow_n = carry[W];

endmodule

// File: rtl/seq_divider_6bit.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one
// quotient bit per clock, with divide-by-zero and overflow detection.
//   clk, rst_n      : clock and synchronous active-low reset
//   start           : request a divide (accepted only in IDLE)
//   dividend        : 2N-bit dividend, sampled on the accept edge
//   divisor         : N-bit divisor, sampled on the accept edge
//   busy            : high in RUN and DONE
//   done            : one-cycle pulse; results valid from this cycle on
//   quotient        : N-bit quotient, held until the next accepted start
//   remainder       : N-bit remainder, held until the next accepted start
//   div_by_zero     : divisor was zero
//   overflow        : quotient would not fit in N bits
module seq_divider_6bit
   import div_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   quotient,
   output logic [N-1:0]   remainder,
   output logic           div_by_zero,
   output logic           overflow
);

   localparam int CNT_W = $clog2(N);

   logic [1:0]       state;
   logic [CNT_W-1:0] count;
   // Only the low half is shifted in during RUN; the high half seeds R.
   logic [N-1:0]     dividend_reg;
   logic [N-1:0]     divisor_reg;
   // R is N+1 bits wide in the datapath, but the overflow pre-check keeps
   // its MSB at zero after every step, so only the low N bits are stored.
   logic [N-1:0]     r_reg;
   logic [N-1:0]     q_reg;

   logic [N:0]       trial;
   logic [N:0]       diff;
   logic             borrow_n;
   logic [N:0]       r_next;
   logic [N-1:0]     q_next;
   logic             r_msb_unused;

   assign trial = {r_reg, dividend_reg[count]};

   rca_sub_7bit #(
      .W (N + 1)
   ) u_sub (
      .a        (trial),
      .b        ({1'b0, divisor_reg}),
      .diff     (diff),
      .borrow_n (borrow_n)
   );

   // Restore mux: keep the trial value when the subtract borrowed.
   assign r_next       = borrow_n ? diff : trial;
   assign r_msb_unused = r_next[N];

   always_comb begin
      q_next        = q_reg;
      q_next[count] = borrow_n;
   end

   assign busy = (state == RUN) || (state == DONE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         count        <= '0;
         dividend_reg <= '0;
         divisor_reg  <= '0;
         r_reg        <= '0;
         q_reg        <= '0;
         quotient     <= '0;
         remainder    <= '0;
         div_by_zero  <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               r_reg <= r_next[N-1:0];
               q_reg <= q_next;
               count <= count - 1'b1;
               if (count == '0) begin
                  state     <= DONE;
                  quotient  <= q_next;
                  remainder <= r_next[N-1:0];
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               // IDLE, and the unused encoding which behaves as IDLE.
               state <= IDLE;
               if (start) begin
                  dividend_reg <= dividend[N-1:0];
                  divisor_reg  <= divisor;
                  div_by_zero  <= 1'b0;
                  overflow     <= 1'b0;
                  quotient     <= '0;
                  remainder    <= '0;
                  q_reg        <= '0;
                  if (divisor == '0) begin
                     state       <= DONE;
                     div_by_zero <= 1'b1;
                  end else if (dividend[2*N-1:N] >= divisor) begin
                     state    <= DONE;
                     overflow <= 1'b1;
                  end else begin
                     state <= RUN;
                     r_reg <= dividend[2*N-1:N];
                     count <= CNT_W'(N - 1);
                  end
               end
            end
         endcase
      end
   end

endmodule
